// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared fetch-unit types and constants
package kamus_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES       = 4;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/kamus_fetch_fifo.sv
// rtl/kamus_fetch_fifo.sv - 2-entry {pc, instr} buffer toward decode with flush
module kamus_fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_data_o,
  output logic [1:0]  count_o
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        do_pop;

  // Entry 0 is always the head; a pop shifts entry 1 down, a push fills the first free slot.
  always_comb begin
    pc0_d  = pc0_q;
    pc1_d  = pc1_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    cnt_d  = cnt_q;
    do_pop = pop_i && (cnt_q != 2'd0);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (do_pop) begin
        pc0_d  = pc1_q;
        dat0_d = dat1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      if (push_i && (cnt_d < DEPTH_C)) begin
        if (cnt_d == 2'd0) begin
          pc0_d  = push_pc_i;
          dat0_d = push_data_i;
        end else begin
          pc1_d  = push_pc_i;
          dat1_d = push_data_i;
        end
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc0_q  <= '0;
      pc1_q  <= '0;
      dat0_q <= '0;
      dat1_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc0_q  <= pc0_d;
      pc1_q  <= pc1_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o     = (cnt_q != 2'd0);
  assign head_pc_o   = pc0_q;
  assign head_data_o = dat0_q;
  assign count_o     = cnt_q;

endmodule

// File: rtl/kamus_fetch_ctrl.sv
// rtl/kamus_fetch_ctrl.sv - fetch PC owner and imem request engine (option: KAMUS_IF_MISALIGN_EN)
module kamus_fetch_ctrl
  import kamus_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = DEFAULT_BOOT_ADDR,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_val_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_misaligned_o
);

  localparam logic [2:0]  MAX_OUT_C = 3'(MAX_OUTSTANDING);
  localparam logic [31:0] PC_STEP   = 32'(INSTR_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pcq0_q, pcq0_d, pcq1_q, pcq1_d;
  logic [1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [1:0]   fifo_count;
  logic         fifo_push, fifo_pop, fifo_flush;
  logic         pop_req, gnt_fire, fetch_en;
  logic [2:0]   credit_used;
  logic [31:0]  redir_tgt;
  logic         redir_misaligned;

  // A head popped this cycle frees its slot now, which keeps 1 instr/cycle with 1-cycle memory.
  assign pop_req     = instr_valid_o & instr_ready_i;
  assign fetch_en    = (state_q == FETCH) || (state_q == DRAIN);
  assign credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_count} - {2'b00, pop_req};
  assign instr_req_o = fetch_en && (credit_used < MAX_OUT_C);
  assign instr_addr_o = fetch_pc_q;
  assign gnt_fire    = instr_req_o & instr_gnt_i;

`ifdef KAMUS_IF_MISALIGN_EN
  assign redir_tgt          = redirect_addr_i;
  assign redir_misaligned   = (redirect_addr_i[1:0] != 2'b00);
  assign instr_misaligned_o = (state_q == HALT);
`else
  assign redir_tgt          = redirect_addr_i & ~(PC_STEP - 32'd1);
  assign redir_misaligned   = 1'b0;
  assign instr_misaligned_o = 1'b0;
`endif

  // Next state: request/response accounting, PC tracking queue, then redirect overrides all.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pcq0_d     = pcq0_q;
    pcq1_d     = pcq1_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + {1'b0, gnt_fire} - {1'b0, instr_rvalid_i};
    fifo_push  = 1'b0;
    fifo_pop   = pop_req;
    fifo_flush = 1'b0;

    if (state_q == BOOT) begin
      fetch_pc_d = BOOT_ADDR;
      state_d    = FETCH;
    end
    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    // Granted addresses queue up in order so each response can be tagged with its PC.
    case ({instr_rvalid_i, gnt_fire})
      2'b10: pcq0_d = pcq1_q;
      2'b01: begin
        if (out_cnt_q == 2'd0) pcq0_d = fetch_pc_q;
        else                   pcq1_d = fetch_pc_q;
      end
      2'b11: begin
        if (out_cnt_q == 2'd1) begin
          pcq0_d = fetch_pc_q;
        end else begin
          pcq0_d = pcq1_q;
          pcq1_d = fetch_pc_q;
        end
      end
      default: ;
    endcase

    if (instr_rvalid_i) begin
      if (drop_cnt_q != 2'd0) drop_cnt_d = drop_cnt_q - 2'd1;
      else                    fifo_push  = 1'b1;
    end
    if ((state_q == DRAIN) && (drop_cnt_d == 2'd0)) begin
      state_d = FETCH;
    end

    // Everything still in flight after this cycle, including a same-cycle grant, is stale.
    if (redirect_i) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      drop_cnt_d = out_cnt_d;
      fetch_pc_d = redir_tgt;
      if (redir_misaligned)         state_d = HALT;
      else if (out_cnt_d != 2'd0)   state_d = DRAIN;
      else                          state_d = FETCH;
    end
  end

  // Control registers; reset drops all in-flight accounting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      fetch_pc_q <= BOOT_ADDR;
      pcq0_q     <= '0;
      pcq1_q     <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pcq0_q     <= pcq0_d;
      pcq1_q     <= pcq1_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  kamus_fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_pc_i   (pcq0_q),
    .push_data_i (instr_rdata_i),
    .pop_i       (fifo_pop),
    .valid_o     (instr_valid_o),
    .head_pc_o   (instr_pc_o),
    .head_data_o (instr_val_o),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_kamus_fetch_ctrl.sv
// tb/tb_kamus_fetch_ctrl.sv - table-driven and scoreboard bench for kamus_fetch_ctrl
module tb_kamus_fetch_ctrl;

  typedef struct {
    logic        gnt;
    logic        ready;
    logic        hold;
    logic        redir;
    logic [31:0] raddr;
    logic        chk;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  localparam int NROWS = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_val_o;
  logic [31:0] instr_pc_o;
  logic        instr_misaligned_o;

  int          n_checks = 0;
  int          n_pass = 0;
  int          pop_cnt = 0;
  logic [31:0] last_pop_pc = 32'h0;
  logic [31:0] model_pc = 32'h0;
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr;
  exp_t        exp_q[$];
  logic [31:0] memq[$];
  vec_t        tbl[NROWS];

  kamus_fetch_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .instr_req_o        (instr_req_o),
    .instr_addr_o       (instr_addr_o),
    .instr_gnt_i        (instr_gnt_i),
    .instr_rvalid_i     (instr_rvalid_i),
    .instr_rdata_i      (instr_rdata_i),
    .redirect_i         (redirect_i),
    .redirect_addr_i    (redirect_addr_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_val_o        (instr_val_o),
    .instr_pc_o         (instr_pc_o),
    .instr_misaligned_o (instr_misaligned_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t row(input logic g, input logic r, input logic req,
                               input logic [31:0] a, input logic v, input logic [31:0] pc);
    vec_t x;
    x.gnt = g; x.ready = r; x.hold = 1'b0; x.redir = 1'b0; x.raddr = 32'h0;
    x.chk = 1'b1; x.exp_req = req; x.exp_addr = a; x.exp_valid = v; x.exp_pc = pc;
    return x;
  endfunction

  function automatic vec_t mk(input logic g, input logic r, input logic h,
                              input logic rd, input logic [31:0] ra);
    vec_t x;
    x = row(g, r, 1'b0, 32'h0, 1'b0, 32'h0);
    x.hold = h; x.redir = rd; x.raddr = ra; x.chk = 1'b0;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock cycle: drive at posedge+1, sample and score at negedge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    instr_gnt_i     = v.gnt;
    instr_ready_i   = v.ready;
    redirect_i      = v.redir;
    redirect_addr_i = v.raddr;
    if (!v.hold && memq.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = memq.pop_front();
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
    end
    @(negedge clk);
    s_req = instr_req_o; s_addr = instr_addr_o; s_valid = instr_valid_o; s_mis = instr_misaligned_o;
    if (v.chk) begin
      chk({tag, "_req"}, 32'(s_req), 32'(v.exp_req));
      chk({tag, "_addr"}, s_addr, v.exp_addr);
      chk({tag, "_valid"}, 32'(s_valid), 32'(v.exp_valid));
      if (v.exp_valid) chk({tag, "_pc"}, instr_pc_o, v.exp_pc);
    end
    if (instr_req_o && v.gnt) begin
      chk({tag, "_gaddr"}, instr_addr_o, model_pc);
      memq.push_back(mem_word(instr_addr_o));
      if (!v.redir) begin
        e.pc = model_pc; e.data = mem_word(model_pc);
        exp_q.push_back(e);
      end
      model_pc = model_pc + 32'd4;
    end
    if (v.redir) begin
      exp_q.delete();
`ifdef KAMUS_IF_MISALIGN_EN
      model_pc = v.raddr;
`else
      model_pc = {v.raddr[31:2], 2'b00};
`endif
    end else if (instr_valid_o && v.ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s_sb: popped pc %h, expected no instruction", tag, instr_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_sb_pc"}, instr_pc_o, e.pc);
        chk({tag, "_sb_data"}, instr_val_o, e.data);
      end
      pop_cnt++;
      last_pop_pc = instr_pc_o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), tag);
  endtask

  task automatic wait_pop(input logic [31:0] exp_pc, input string tag);
    int start;
    start = pop_cnt;
    for (int i = 0; i < 12 && pop_cnt == start; i++) step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), tag);
    chk({tag, "_seen"}, 32'(pop_cnt != start), 32'd1);
    chk({tag, "_first_pc"}, last_pop_pc, exp_pc);
  endtask

  initial begin
    int p0;
    tbl[0]  = row(1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00);
    tbl[1]  = row(1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
    tbl[2]  = row(1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
    tbl[3]  = row(1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
    tbl[4]  = row(1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
    tbl[5]  = row(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
    tbl[6]  = row(1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C);
    tbl[7]  = row(1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[8]  = row(1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[9]  = row(1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[10] = row(1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[11] = row(1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h10);
    tbl[12] = row(1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10);
    tbl[13] = row(1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14);
    tbl[14] = row(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_val", instr_val_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk("rst_mis", 32'(instr_misaligned_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NROWS; i++) step(tbl[i], $sformatf("row%0d", i));

    p0 = pop_cnt;
    run(8, "thru");
    chk("thru_pops", 32'(pop_cnt - p0), 32'd8);

    // Two responses in flight when the redirect lands.
    for (int i = 0; i < 3; i++) step(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0), "hold");
    chk("hold_req_full", 32'(s_req), 32'd0);
    step(mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h100), "r100");
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), "r100n1");
    chk("r100_valid", 32'(s_valid), 32'd0);
    chk("r100_addr", s_addr, 32'h100);
    chk("r100_req", 32'(s_req), 32'd0);
    wait_pop(32'h100, "r100w");
    run(4, "steady1");

    // Redirect coinciding with a grant and a response.
    step(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h200), "r200");
    chk("r200_req_same", 32'(s_req), 32'd1);
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), "r200n1");
    chk("r200_valid", 32'(s_valid), 32'd0);
    chk("r200_addr", s_addr, 32'h200);
    chk("r200_req", 32'(s_req), 32'd1);
    wait_pop(32'h200, "r200w");
    run(4, "steady2");

    // Grant withheld: address must hold, then follow a redirect.
    for (int i = 0; i < 4; i++) begin
      step(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0), $sformatf("stall%0d", i));
      chk($sformatf("stall%0d_req", i), 32'(s_req), 32'd1);
      chk($sformatf("stall%0d_addr", i), s_addr, model_pc);
    end
    step(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h300), "r300");
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), "r300n1");
    chk("r300_addr", s_addr, 32'h300);
    chk("r300_req", 32'(s_req), 32'd1);
    chk("r300_valid", 32'(s_valid), 32'd0);
    wait_pop(32'h300, "r300w");
    run(3, "steady3");

    step(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h102), "r102");
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), "r102n1");
`ifdef KAMUS_IF_MISALIGN_EN
    chk("r102_mis", 32'(s_mis), 32'd1);
    chk("r102_req", 32'(s_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), "halt");
      chk($sformatf("halt%0d_req", i), 32'(s_req), 32'd0);
      chk($sformatf("halt%0d_mis", i), 32'(s_mis), 32'd1);
    end
    step(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h200), "resume");
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0), "resumen1");
    chk("resume_mis", 32'(s_mis), 32'd0);
    chk("resume_addr", s_addr, 32'h200);
    wait_pop(32'h200, "resumew");
`else
    chk("r102_mis", 32'(s_mis), 32'd0);
    chk("r102_addr", s_addr, 32'h100);
    wait_pop(32'h100, "r102w");
`endif
    run(3, "steady4");

    // Reset in the middle of traffic.
    rst = 1'b1;
    instr_rvalid_i = 1'b0;
    #1;
    chk("mid_rst_req", 32'(instr_req_o), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_rst_addr", instr_addr_o, 32'h0);
    memq.delete();
    exp_q.delete();
    model_pc = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(tbl[i], $sformatf("rrow%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
